// File: rtl/id_issue_ctrl.sv
// id_issue_ctrl: decode-stage issue/interlock controller.
// Decides each cycle whether the instruction in ID may move to EX, based on
// a 32-entry load scoreboard (RAW/WAW against outstanding loads) and a HI/LO
// multiply/divide busy state machine.
// Optional feature macro: ID_STALL_CNT_EN adds a saturating hazard-stall
// cycle counter on stall_cnt. Without it, stall_cnt is tied to zero.
module id_issue_ctrl #(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 33
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        id_valid,
    input  logic [4:0]  rreg_a,
    input  logic [4:0]  rreg_b,
    input  logic        use_a,
    input  logic        use_b,
    input  logic [4:0]  wreg,
    input  logic        wreg_en,
    input  logic        is_load,
    input  logic [1:0]  is_muldiv,
    input  logic        reads_hilo,
    input  logic        ex_ready,
    input  logic        flush,
    input  logic        wb_ld_valid,
    input  logic [4:0]  wb_ld_reg,
    output logic        id_ready,
    output logic        issue,
    output logic        hilo_busy,
    output logic [31:0] pending,
    output logic [31:0] stall_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } hilo_state_t;

    // Counter reload values: the unit stays busy for LAT-1 cycles after issue.
    localparam logic [5:0] MUL_CNT = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_CNT = 6'(DIV_LAT - 1);

    hilo_state_t state_reg, state_next;
    logic [5:0]  cnt_reg, cnt_next;
    logic [31:0] pending_reg, pending_next;
    logic [31:0] wb_clr_mask;
    logic [31:0] pend_eff;
    logic        raw_hazard, waw_hazard, hilo_hazard;
    logic        ld_set;

    // One-hot mask of the register a load writes back this cycle.
    always_comb begin
        wb_clr_mask = '0;
        if (wb_ld_valid) begin
            wb_clr_mask[wb_ld_reg] = 1'b1;
        end
    end

    // WB-to-ID bypass: a register being written back this cycle is already safe.
    assign pend_eff = pending_reg & ~wb_clr_mask;

    // Bit 0 of the scoreboard is never set, so $zero never hazards.
    assign raw_hazard  = (use_a & pend_eff[rreg_a]) | (use_b & pend_eff[rreg_b]);
    assign waw_hazard  = wreg_en & pend_eff[wreg] & (wreg != 5'd0);
    assign hilo_hazard = hilo_busy & (reads_hilo | (is_muldiv != 2'b00));

    assign id_ready  = ex_ready & ~(raw_hazard | waw_hazard | hilo_hazard);
    assign issue     = id_valid & id_ready & ~flush;
    assign hilo_busy = (state_reg == BUSY);
    assign pending   = pending_reg;

    assign ld_set = issue & is_load & wreg_en & (wreg != 5'd0);

    // Scoreboard update: writeback clear first, then issue set, so set wins.
    always_comb begin
        pending_next = pend_eff;
        if (ld_set) begin
            pending_next[wreg] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    // HI/LO busy FSM: start on mult/div issue, count down to idle.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (issue && is_muldiv == 2'b01) begin
                    cnt_next = MUL_CNT;
                    if (MUL_CNT != 6'd0) state_next = BUSY;
                end else if (issue && is_muldiv == 2'b10) begin
                    cnt_next = DIV_CNT;
                    if (DIV_CNT != 6'd0) state_next = BUSY;
                end
            end
            BUSY: begin
                cnt_next = cnt_reg - 6'd1;
                if (cnt_reg <= 6'd1) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State registers for the scoreboard and HI/LO FSM.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending_reg <= '0;
            state_reg   <= IDLE;
            cnt_reg     <= '0;
        end else begin
            pending_reg <= pending_next;
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
        end
    end

`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;
    logic        count_stall;

    // Only hazard stalls count; EX back-pressure (ex_ready=0) does not.
    assign count_stall = id_valid & ~flush & ~id_ready & ex_ready;

    // Saturating hazard-stall counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_reg <= '0;
        end else if (count_stall && stall_cnt_reg != 32'hFFFF_FFFF) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed testbench for id_issue_ctrl (MUL_LAT=2, DIV_LAT=33).
module tb_id_issue_ctrl;

`ifdef ID_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        id_valid;
    logic [4:0]  rreg_a, rreg_b, wreg, wb_ld_reg;
    logic        use_a, use_b, wreg_en, is_load, reads_hilo;
    logic [1:0]  is_muldiv;
    logic        ex_ready, flush, wb_ld_valid;
    logic        id_ready, issue, hilo_busy;
    logic [31:0] pending, stall_cnt;

    int checks = 0;
    int errors = 0;
    int exp_stalls = 0;

    id_issue_ctrl #(.MUL_LAT(2), .DIV_LAT(33)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .id_valid   (id_valid),
        .rreg_a     (rreg_a),
        .rreg_b     (rreg_b),
        .use_a      (use_a),
        .use_b      (use_b),
        .wreg       (wreg),
        .wreg_en    (wreg_en),
        .is_load    (is_load),
        .is_muldiv  (is_muldiv),
        .reads_hilo (reads_hilo),
        .ex_ready   (ex_ready),
        .flush      (flush),
        .wb_ld_valid(wb_ld_valid),
        .wb_ld_reg  (wb_ld_reg),
        .id_ready   (id_ready),
        .issue      (issue),
        .hilo_busy  (hilo_busy),
        .pending    (pending),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    task automatic clr();
        id_valid = 0; rreg_a = 0; rreg_b = 0; use_a = 0; use_b = 0;
        wreg = 0; wreg_en = 0; is_load = 0; is_muldiv = 2'b00; reads_hilo = 0;
        ex_ready = 1; flush = 0; wb_ld_valid = 0; wb_ld_reg = 0;
    endtask

    task automatic lw(input logic [4:0] dst, input logic [4:0] base);
        clr();
        id_valid = 1; is_load = 1; wreg = dst; wreg_en = 1; rreg_a = base; use_a = 1;
    endtask

    task automatic alu(input logic [4:0] dst, input logic [4:0] a, input logic [4:0] b);
        clr();
        id_valid = 1; wreg = dst; wreg_en = 1; rreg_a = a; rreg_b = b; use_a = 1; use_b = 1;
    endtask

    task automatic muldiv(input logic [1:0] kind);
        clr();
        id_valid = 1; is_muldiv = kind; rreg_a = 5'd1; rreg_b = 5'd2; use_a = 1; use_b = 1;
    endtask

    task automatic mfhilo(input logic [4:0] dst);
        clr();
        id_valid = 1; reads_hilo = 1; wreg = dst; wreg_en = 1;
    endtask

    initial begin
        clr();
        resetn = 0;
        #2;
        check("rst_pending", pending, 32'h0);
        check("rst_hilo_busy", {31'b0, hilo_busy}, 32'h0);
        check("rst_stall_cnt", stall_cnt, 32'h0);
        tick(); tick();
        #2 resetn = 1;

        // Load-use: lw $5 then addu $6,$5,$7; wb for $5 on the 4th cycle.
        tick(); lw(5, 1); settle();
        check("lu_lw_issue", {31'b0, issue}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick(); alu(6, 5, 7); settle();
            check("lu_stall_ready", {31'b0, id_ready}, 32'h0);
            check("lu_stall_issue", {31'b0, issue}, 32'h0);
        end
        exp_stalls += 3;
        tick(); alu(6, 5, 7); wb_ld_valid = 1; wb_ld_reg = 5; settle();
        check("lu_wb_pending5", pending, 32'h0000_0020);
        check("lu_wb_issue", {31'b0, issue}, 32'h1);
        tick(); clr(); settle();
        check("lu_pending_clear", pending, 32'h0);

        // Same-cycle set/clear of $8: set wins, bypass removes WAW.
        tick(); lw(8, 2); settle();
        check("sc_first_issue", {31'b0, issue}, 32'h1);
        tick(); lw(8, 2); wb_ld_valid = 1; wb_ld_reg = 8; settle();
        check("sc_second_issue", {31'b0, issue}, 32'h1);
        tick(); clr(); settle();
        check("sc_pending8", pending, 32'h0000_0100);
        tick(); clr(); wb_ld_valid = 1; wb_ld_reg = 8;
        tick(); clr(); settle();
        check("sc_pending_clear", pending, 32'h0);

        // $zero: lw $0 never sets a bit, use of $0 never stalls.
        tick(); lw(0, 0); settle();
        check("z_lw_issue", {31'b0, issue}, 32'h1);
        tick(); alu(4, 0, 0); settle();
        check("z_use_ready", {31'b0, id_ready}, 32'h1);
        check("z_pending", pending, 32'h0);

        // WAW: second lw $9 stalls until wb of $9.
        tick(); lw(9, 3); settle();
        check("waw_first_issue", {31'b0, issue}, 32'h1);
        for (int i = 0; i < 2; i++) begin
            tick(); lw(9, 3); settle();
            check("waw_pending9", pending, 32'h0000_0200);
            check("waw_stall_ready", {31'b0, id_ready}, 32'h0);
        end
        exp_stalls += 2;
        tick(); lw(9, 3); wb_ld_valid = 1; wb_ld_reg = 9; settle();
        check("waw_wb_issue", {31'b0, issue}, 32'h1);
        tick(); clr(); settle();
        check("waw_pending9_again", pending, 32'h0000_0200);
        tick(); clr(); wb_ld_valid = 1; wb_ld_reg = 9;
        tick(); clr(); settle();
        check("waw_pending_clear", pending, 32'h0);

        // Flush with lw in ID: no issue, no scoreboard set.
        tick(); lw(10, 3); flush = 1; settle();
        check("fl_ready", {31'b0, id_ready}, 32'h1);
        check("fl_issue", {31'b0, issue}, 32'h0);
        tick(); clr(); settle();
        check("fl_pending", pending, 32'h0);

        // EX back-pressure is not a hazard stall.
        tick(); alu(11, 1, 2); ex_ready = 0; settle();
        check("bp_ready", {31'b0, id_ready}, 32'h0);
        check("bp_issue", {31'b0, issue}, 32'h0);
        tick(); clr(); settle();
        check("bp_stall_cnt", stall_cnt, CNT_EN ? 32'(exp_stalls) : 32'h0);

        // HI/LO: div then mflo stalls 32 cycles; a mult presented meanwhile stalls too.
        tick(); muldiv(2'b10); settle();
        check("div_issue", {31'b0, issue}, 32'h1);
        check("div_busy_pre", {31'b0, hilo_busy}, 32'h0);
        for (int i = 0; i < 32; i++) begin
            tick();
            if (i < 30) mfhilo(3);
            else muldiv(2'b01);
            settle();
            check("div_busy", {31'b0, hilo_busy}, 32'h1);
            check("div_stall_ready", {31'b0, id_ready}, 32'h0);
        end
        exp_stalls += 32;
        tick(); mfhilo(3); settle();
        check("div_done_busy", {31'b0, hilo_busy}, 32'h0);
        check("div_mflo_issue", {31'b0, issue}, 32'h1);

        // mult (MUL_LAT=2) then mfhi: exactly one stall cycle.
        tick(); muldiv(2'b01); settle();
        check("mul_issue", {31'b0, issue}, 32'h1);
        tick(); mfhilo(4); settle();
        check("mul_busy", {31'b0, hilo_busy}, 32'h1);
        check("mul_mfhi_stall", {31'b0, issue}, 32'h0);
        exp_stalls += 1;
        tick(); mfhilo(4); settle();
        check("mul_busy_done", {31'b0, hilo_busy}, 32'h0);
        check("mul_mfhi_issue", {31'b0, issue}, 32'h1);
        tick(); clr(); settle();
        check("total_stall_cnt", stall_cnt, CNT_EN ? 32'(exp_stalls) : 32'h0);

        // Reset mid-operation: outstanding load and busy divider both cleared.
        tick(); lw(12, 1); settle();
        check("rm_lw_issue", {31'b0, issue}, 32'h1);
        tick(); muldiv(2'b10); settle();
        check("rm_div_issue", {31'b0, issue}, 32'h1);
        tick(); clr(); settle();
        check("rm_pending12", pending, 32'h0000_1000);
        check("rm_busy", {31'b0, hilo_busy}, 32'h1);
        #2 resetn = 0;
        #1;
        check("rm_async_pending", pending, 32'h0);
        check("rm_async_busy", {31'b0, hilo_busy}, 32'h0);
        check("rm_async_stall_cnt", stall_cnt, 32'h0);
        tick();
        #2 resetn = 1;
        tick(); mfhilo(5); settle();
        check("rm_after_mflo_issue", {31'b0, issue}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
